shift_reg_rr_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one shift_registers instance among NUM_REQ requesters.

---
 rtl/shift_reg_rr_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/shift_reg_rr_arbiter.sv
// Round-robin arbiter that grants one requester at a time and plays its snapshotted
// mode/word onto the shared shift-register control pins, one beat per clock.
module shift_reg_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SIPO_BEATS  = 4,
  parameter int PISO_SHIFTS = 3
) (
  input  logic                 shift_reg_clk,
  input  logic                 shift_reg_rst_n,
  input  logic [NUM_REQ-1:0]   arb_req,
  input  logic [2*NUM_REQ-1:0] arb_mode,
  input  logic [4*NUM_REQ-1:0] arb_din,
  output logic [NUM_REQ-1:0]   arb_gnt,
  output logic [NUM_REQ-1:0]   arb_done,
  output logic                 arb_busy,
  output logic [3:0]           shift_reg_one_hot,
  output logic                 shift_reg_din_vld,
  output logic                 shift_piso_load,
  output logic [3:0]           shift_reg_din
);

  // state | meaning
  // IDLE  | no transaction; arbitrate among arb_req every cycle
  // RUN   | granted transaction streaming beats to the shift register
  // DONE  | one-cycle completion pulse, grant still held, pointer advanced
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXB = (SIPO_BEATS > PISO_SHIFTS + 1) ? SIPO_BEATS : PISO_SHIFTS + 1;
  localparam int CW   = $clog2(MAXB) + 1;

  localparam logic [1:0] M_SISO = 2'd0;
  localparam logic [1:0] M_SIPO = 2'd1;
  localparam logic [1:0] M_PISO = 2'd2;

  state_t        state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] idx_q;
  logic [1:0]    mode_q;
  logic [3:0]    data_q;
  logic [CW-1:0] cnt_q;

  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  logic [1:0]    pick_mode;
  logic [3:0]    pick_data;
  logic [CW-1:0] pick_cnt;

  // cnt holds the number of beats still to follow the current one
  function automatic logic [CW-1:0] last_cnt(input logic [1:0] m);
    case (m)
      M_SIPO:  return CW'(SIPO_BEATS - 1);
      M_PISO:  return CW'(PISO_SHIFTS);
      default: return '0;
    endcase
  endfunction

  // SIPO sends MSB first, so the bit for a beat is data[remaining beats]
  function automatic logic [3:0] beat_din(input logic [1:0] m, input logic [3:0] d,
                                          input logic [CW-1:0] c);
    logic [3:0] s;
    s = d >> c;
    case (m)
      M_SISO:  return {3'b000, d[0]};
      M_SIPO:  return {3'b000, s[0]};
      default: return d;
    endcase
  endfunction

  always_comb begin
    int cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!pick_vld && arb_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(cand);
      end
    end
    pick_mode = arb_mode[2*int'(pick_idx) +: 2];
    pick_data = arb_din[4*int'(pick_idx) +: 4];
    pick_cnt  = last_cnt(pick_mode);
  end

  always_ff @(posedge shift_reg_clk) begin
    if (!shift_reg_rst_n) begin
      state_q           <= ST_IDLE;
      ptr_q             <= PW'(NUM_REQ - 1);
      idx_q             <= '0;
      mode_q            <= '0;
      data_q            <= '0;
      cnt_q             <= '0;
      arb_gnt           <= '0;
      arb_done          <= '0;
      arb_busy          <= 1'b0;
      shift_reg_one_hot <= '0;
      shift_reg_din_vld <= 1'b0;
      shift_piso_load   <= 1'b0;
      shift_reg_din     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          arb_done <= '0;
          if (pick_vld) begin
            state_q           <= ST_RUN;
            idx_q             <= pick_idx;
            mode_q            <= pick_mode;
            data_q            <= pick_data;
            cnt_q             <= pick_cnt;
            arb_gnt           <= NUM_REQ'(1) << pick_idx;
            arb_busy          <= 1'b1;
            shift_reg_one_hot <= 4'b0001 << pick_mode;
            shift_reg_din_vld <= 1'b1;
            shift_piso_load   <= (pick_mode == M_PISO);
            shift_reg_din     <= beat_din(pick_mode, pick_data, pick_cnt);
          end else begin
            arb_gnt           <= '0;
            arb_busy          <= 1'b0;
            shift_reg_one_hot <= '0;
            shift_reg_din_vld <= 1'b0;
            shift_piso_load   <= 1'b0;
            shift_reg_din     <= '0;
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) begin
            state_q           <= ST_DONE;
            arb_done          <= NUM_REQ'(1) << idx_q;
            shift_reg_one_hot <= '0;
            shift_reg_din_vld <= 1'b0;
            shift_piso_load   <= 1'b0;
            shift_reg_din     <= '0;
          end else begin
            cnt_q           <= cnt_q - 1'b1;
            shift_piso_load <= 1'b0;
            shift_reg_din   <= beat_din(mode_q, data_q, cnt_q - 1'b1);
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          ptr_q    <= idx_q;
          arb_gnt  <= '0;
          arb_done <= '0;
          arb_busy <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
